// File: rtl/window_motor_controller.sv
// Window motor controller: timed open/close travel with position tracking,
// stop-mid-travel on a repeat press, and auto-reverse on obstruction while closing.
module window_motor_controller #(
  parameter int unsigned POS_W        = 4,
  parameter int unsigned TRAVEL_TICKS = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             press,
  input  logic             obstruct,
  output logic             open_cw,
  output logic             close_ccw,
  output logic [POS_W-1:0] position,
  output logic [2:0]       state,
  output logic             fault
);

  localparam logic [2:0] CLOSED  = 3'd0;
  localparam logic [2:0] OPENING = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] CLOSING = 3'd3;
  localparam logic [2:0] STOPPED = 3'd4;

  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL_TICKS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TRAVEL_TICKS - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic             press_q;
  logic             last_open;   // last travel direction: 1 = open, 0 = close
  logic             press_edge;
  logic [2:0]       state_n;
  logic [POS_W-1:0] position_n;
  logic             fault_n;
  logic             last_open_n;

  assign press_edge = press & ~press_q;

  // Next-state, position, direction memory and fault flag
  always_comb begin
    state_n     = state;
    position_n  = position;
    fault_n     = fault;
    last_open_n = last_open;
    case (state)
      CLOSED: begin
        if (press_edge) begin
          state_n     = OPENING;
          last_open_n = 1'b1;
        end
      end
      OPENING: begin
        if (press_edge) begin
          state_n = STOPPED;
        end else begin
          // A reversal in the very first closing cycle re-enters OPENING at the
          // top position; hold there rather than step past full travel.
          if (position < POS_TOP) position_n = position + POS_ONE;
          if (position >= POS_LAST) state_n = OPEN;
        end
      end
      OPEN: begin
        if (press_edge) begin
          state_n     = CLOSING;
          last_open_n = 1'b0;
        end
      end
      CLOSING: begin
        if (obstruct) begin
          state_n     = OPENING;
          fault_n     = 1'b1;
          last_open_n = 1'b1;
        end else if (press_edge) begin
          state_n = STOPPED;
        end else begin
          if (position != '0) position_n = position - POS_ONE;
          if (position <= POS_ONE) state_n = CLOSED;
        end
      end
      STOPPED: begin
        if (press_edge) begin
          if (last_open) begin
            state_n     = CLOSING;
            last_open_n = 1'b0;
          end else begin
            state_n     = OPENING;
            last_open_n = 1'b1;
          end
        end
      end
      default: state_n = CLOSED;
    endcase
    if (state_n == CLOSED && state != CLOSED) fault_n = 1'b0;
  end

  // State, position and registered Moore drive outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLOSED;
      position  <= '0;
      fault     <= 1'b0;
      press_q   <= 1'b0;
      last_open <= 1'b0;
      open_cw   <= 1'b0;
      close_ccw <= 1'b0;
    end else begin
      state     <= state_n;
      position  <= position_n;
      fault     <= fault_n;
      press_q   <= press;
      last_open <= last_open_n;
      open_cw   <= (state_n == OPENING);
      close_ccw <= (state_n == CLOSING);
    end
  end

endmodule

// File: tb/tb_window_motor_controller.sv
// Scoreboard bench for window_motor_controller with TRAVEL_TICKS=4.
module tb_window_motor_controller;

  localparam int PW = 4;
  localparam int TT = 4;

  localparam int S_CLOSED  = 0;
  localparam int S_OPENING = 1;
  localparam int S_OPEN    = 2;
  localparam int S_CLOSING = 3;
  localparam int S_STOPPED = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          press = 1'b0;
  logic          obstruct = 1'b0;
  logic          open_cw;
  logic          close_ccw;
  logic [PW-1:0] position;
  logic [2:0]    state;
  logic          fault;

  window_motor_controller #(.POS_W(PW), .TRAVEL_TICKS(TT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .press     (press),
    .obstruct  (obstruct),
    .open_cw   (open_cw),
    .close_ccw (close_ccw),
    .position  (position),
    .state     (state),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int pos;
    bit oc;
    bit cc;
    bit flt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  // Behavioural reference: window as a position on [0, TT] with a mode.
  int m_st;
  int m_pos;
  bit m_flt;
  bit m_last_open;
  bit m_pq;

  function automatic void model_reset();
    m_st = S_CLOSED;
    m_pos = 0;
    m_flt = 0;
    m_last_open = 0;
    m_pq = 0;
  endfunction

  function automatic void model_edge(bit p, bit o);
    bit pe;
    int nxt;
    pe = p && !m_pq;
    m_pq = p;
    nxt = m_st;
    case (m_st)
      S_CLOSED:  if (pe) begin nxt = S_OPENING; m_last_open = 1; end
      S_OPENING: if (pe) nxt = S_STOPPED;
                 else begin
                   m_pos = (m_pos + 1 > TT) ? TT : m_pos + 1;
                   if (m_pos == TT) nxt = S_OPEN;
                 end
      S_OPEN:    if (pe) begin nxt = S_CLOSING; m_last_open = 0; end
      S_CLOSING: if (o) begin nxt = S_OPENING; m_flt = 1; m_last_open = 1; end
                 else if (pe) nxt = S_STOPPED;
                 else begin
                   m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                   if (m_pos == 0) nxt = S_CLOSED;
                 end
      S_STOPPED: if (pe) begin
                   nxt = m_last_open ? S_CLOSING : S_OPENING;
                   m_last_open = !m_last_open;
                 end
      default:   nxt = S_CLOSED;
    endcase
    if (nxt == S_CLOSED && m_st != S_CLOSED) m_flt = 0;
    m_st = nxt;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st  = m_st;
    e.pos = m_pos;
    e.oc  = (m_st == S_OPENING);
    e.cc  = (m_st == S_CLOSING);
    e.flt = m_flt;
    sb.push_back(e);
  endfunction

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic step(input bit r, input bit p, input bit o);
    @(negedge clock);
    reset_n  = r;
    press    = p;
    obstruct = o;
    if (!r) model_reset();
    else model_edge(p, o);
    push_exp();
  endtask

  task automatic hold(input int n, input bit p, input bit o);
    repeat (n) step(1'b1, p, o);
  endtask

  // Reset asserted mid-cycle, away from any clock edge; checked without a clock.
  task automatic async_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    model_reset();
    push_exp();
    ->chk_now;
    #2;
  endtask

  // Monitor: compare DUT outputs with the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or chk_now);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("state",     int'(state),     e.st);
        cmp("position",  int'(position),  e.pos);
        cmp("open_cw",   int'(open_cw),   int'(e.oc));
        cmp("close_ccw", int'(close_ccw), int'(e.cc));
        cmp("fault",     int'(fault),     int'(e.flt));
        cmp("drive_excl", int'(open_cw & close_ccw), 0);
      end
    end
  end

  initial begin
    bit rp;
    model_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // full open from a one-cycle press
    step(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0, 1'b0);
    // close with press held for 10 cycles: single edge
    hold(10, 1'b1, 1'b0);
    hold(2, 1'b0, 1'b0);

    // stop mid-opening at position 2, then resume closing
    step(1'b1, 1'b1, 1'b0);
    hold(2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(4, 1'b0, 1'b0);

    // obstruction at position 2 while closing, then close with fault clearing
    step(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(6, 1'b0, 1'b0);

    // obstruct and press edge together while closing
    step(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(6, 1'b0, 1'b0);

    // obstruct ignored in CLOSED and OPENING
    hold(2, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    hold(2, 1'b0, 1'b1);
    hold(3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(6, 1'b0, 1'b0);

    // reset mid-opening at position 3, then a normal open
    step(1'b1, 1'b1, 1'b0);
    hold(3, 1'b0, 1'b0);
    async_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0, 1'b0);

    // randomized press/obstruct traffic with occasional asynchronous resets
    rp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) rp = ~rp;
      if ($urandom_range(0, 99) == 0) async_reset();
      step(1'b1, rp, $urandom_range(0, 9) == 0);
    end

    // let the final predictions drain, bounded
    for (int k = 0; k < 4 && sb.size() > 0; k++) begin
      @(posedge clock);
      #2;
    end
    cmp("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
